// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-read-port architectural register file with a pending-write scoreboard.
// It has write-to-read bypass, an optional hard-wired zero register, and two
// snoop outputs that mirror fixed entries. After reset a clear sequencer
// writes zero to every entry, one per cycle. Because of that, the storage
// array itself has no reset.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   init_busy        high while the clear sequencer runs
//   rd_addr          NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data          NUM_RD packed registered read data
//   rd_pending       registered scoreboard bit for each read address
//   we/wr_addr/wr_data   write port
//   sb_set/sb_addr   marks an entry as having an outstanding producer
//   sys_call_reg     registered copy of entry SNOOP_A
//   std_out_address  registered copy of entry SNOOP_B
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int SNOOP_A  = 2,
  parameter int SNOOP_B  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_busy,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [DATA_W-1:0]          sys_call_reg,
  output logic [DATA_W-1:0]          std_out_address
);

  localparam int DEPTH  = 2 ** ADDR_W;
  // The read ports and the two snoop taps share one lookup path.
  localparam int NUM_LK = NUM_RD + 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         clear_cnt_q, clear_cnt_d;
  logic [DEPTH-1:0]          pending_q, pending_d;
  logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]         rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0]         sys_call_q, sys_call_d;
  logic [DATA_W-1:0]         std_out_q, std_out_d;

  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [DATA_W-1:0]         mem_wdata;

  logic                      ready;
  logic                      wr_valid;
  logic                      sb_valid;
  logic [ADDR_W-1:0]         lk_addr [NUM_LK];
  logic [DATA_W-1:0]         lk_data [NUM_LK];

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // State and output registers; every externally visible register resets to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      clear_cnt_q  <= '0;
      pending_q    <= '0;
      rd_data_q    <= '0;
      rd_pending_q <= '0;
      sys_call_q   <= '0;
      std_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      pending_q    <= pending_d;
      rd_data_q    <= rd_data_d;
      rd_pending_q <= rd_pending_d;
      sys_call_q   <= sys_call_d;
      std_out_q    <= std_out_d;
    end
  end

  // Next state: the sequencer walks every entry once, then moves to READY.
  // The counter wraps back to zero on the last entry.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == CLEAR) begin
      clear_cnt_d = clear_cnt_q + 1'b1;
      if (clear_cnt_q == '1) begin
        state_d = READY;
      end
    end
  end

  // State-decoded outputs.
  always_comb begin
    init_busy = 1'b1;
    ready     = 1'b0;
    if (state_q == READY) begin
      init_busy = 1'b0;
      ready     = 1'b1;
    end
  end

  // Qualified write and scoreboard-set strobes. The zero register ignores both.
  always_comb begin
    wr_valid = ready && we && !is_zero_reg(wr_addr);
    sb_valid = ready && sb_set && !is_zero_reg(sb_addr);
  end

  // The storage write port is shared by the clear sequencer and the real write port.
  always_comb begin
    mem_we    = wr_valid;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = clear_cnt_q;
      mem_wdata = '0;
    end
  end

  // Storage array with no reset. The clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Collect lookup addresses: the read ports first, then the two snoop taps.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      lk_addr[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end
    lk_addr[NUM_RD]     = ADDR_W'(SNOOP_A);
    lk_addr[NUM_RD + 1] = ADDR_W'(SNOOP_B);
  end

  // Lookup with bypass: a write to the same entry in this cycle wins over the array.
  always_comb begin
    for (int k = 0; k < NUM_LK; k++) begin
      lk_data[k] = '0;
      if (ready && !is_zero_reg(lk_addr[k])) begin
        if (wr_valid && (wr_addr == lk_addr[k])) begin
          lk_data[k] = wr_data;
        end else begin
          lk_data[k] = mem[lk_addr[k]];
        end
      end
    end
  end

  // Scoreboard update. The set is applied after the clear so that a new producer
  // in the same cycle overrides the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (wr_valid) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (sb_valid) begin
      pending_d[sb_addr] = 1'b1;
    end
  end

  // Next values of the output registers. Pending reflects the already-updated scoreboard.
  always_comb begin
    rd_data_d    = '0;
    rd_pending_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_d[i*DATA_W +: DATA_W] = lk_data[i];
      rd_pending_d[i]               = pending_d[lk_addr[i]];
    end
    sys_call_d = lk_data[NUM_RD];
    std_out_d  = lk_data[NUM_RD + 1];
  end

  assign rd_data         = rd_data_q;
  assign rd_pending      = rd_pending_q;
  assign sys_call_reg    = sys_call_q;
  assign std_out_address = std_out_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp with its default parameters.
// The reference model is a plain array of register values and pending flags.
// Each cycle, that cycle's write and scoreboard set are applied to the model
// first. The model is then read, which gives both the bypass and the
// "set wins" behaviour. The clear phase is modelled as a countdown of cycles
// since reset release.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      init_busy;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]         rd_pending;
  logic                      we;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      sb_set;
  logic [ADDR_W-1:0]         sb_addr;
  logic [DATA_W-1:0]         sys_call_reg;
  logic [DATA_W-1:0]         std_out_address;

  // Reference model state and the expected outputs after the last edge.
  logic [DATA_W-1:0]         m_mem [DEPTH];
  logic                      m_pend [DEPTH];
  int                        m_clear_left;
  logic [NUM_RD*DATA_W-1:0]  exp_rd_data;
  logic [NUM_RD-1:0]         exp_rd_pending;
  logic [DATA_W-1:0]         exp_sys;
  logic [DATA_W-1:0]         exp_std;
  logic                      exp_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .ZERO_REG(1), .SNOOP_A(2), .SNOOP_B(4)
  ) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .sys_call_reg(sys_call_reg), .std_out_address(std_out_address)
  );

  // Guard against a hung run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_clear_left   = DEPTH;
    exp_rd_data    = '0;
    exp_rd_pending = '0;
    exp_sys        = '0;
    exp_std        = '0;
    exp_busy       = 1'b1;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    logic [ADDR_W-1:0] a;
    if (m_clear_left > 0) begin
      m_clear_left--;
      exp_rd_data    = '0;
      exp_rd_pending = '0;
      exp_sys        = '0;
      exp_std        = '0;
    end else begin
      if (we && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (sb_set && sb_addr != 0) begin
        m_pend[sb_addr] = 1'b1;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        a = rd_addr[p*ADDR_W +: ADDR_W];
        exp_rd_data[p*DATA_W +: DATA_W] = m_mem[a];
        exp_rd_pending[p]               = m_pend[a];
      end
      exp_sys = m_mem[2];
      exp_std = m_mem[4];
    end
    exp_busy = (m_clear_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    we      = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  // Runs the clear phase from reset release and counts the cycles init_busy stays high.
  // While the phase runs, a write of all-ones to entry 3 is held on the write port.
  task automatic test_clear_sequence();
    int busy_cycles;
    busy_cycles = 0;
    we      = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hFFFF_FFFF;
    rd_addr = {5'd3, 5'd3};
    for (int c = 0; c < 40; c++) begin
      vectors++;
      if (init_busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL clear_busy cyc %0d: got %b expected %b", c, init_busy, exp_busy);
      end
      if (!init_busy) break;
      busy_cycles++;
      vectors++;
      if (rd_data !== '0 || sys_call_reg !== '0 || std_out_address !== '0) begin
        miscompares++;
        $display("[TB] FAIL clear_outputs cyc %0d: got rd=%h sys=%h std=%h expected 0",
                 c, rd_data, sys_call_reg, std_out_address);
      end
      tick();
    end
    we = 1'b0;
    vectors++;
    if (busy_cycles != DEPTH) begin
      miscompares++;
      $display("[TB] FAIL clear_length: got %0d expected %0d", busy_cycles, DEPTH);
    end
    // Entry 3 must still hold zero because the writes during clear were ignored.
    tick();
    vectors++;
    if (rd_data !== exp_rd_data || exp_rd_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL no_write_in_clear: got %h expected %h", rd_data, exp_rd_data);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rd_addr = '0;
    rst = 1'b1;
    model_reset();
    #2;
    vectors++;
    if (init_busy !== 1'b1 || rd_data !== '0 || rd_pending !== '0 ||
        sys_call_reg !== '0 || std_out_address !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got busy=%b rd=%h pend=%b sys=%h std=%h expected 1/0/0/0/0",
               init_busy, rd_data, rd_pending, sys_call_reg, std_out_address);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    test_clear_sequence();
    // A write after init_busy falls is accepted.
    we = 1'b1;
    tick();
    we = 1'b0;
    vectors++;
    if (rd_data !== exp_rd_data) begin
      miscompares++;
      $display("[TB] FAIL first_write: got %h expected %h", rd_data, exp_rd_data);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    we      = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h1234_5678;
    rd_addr = {5'd6, 5'd5};
    tick();
    vectors++;
    if (rd_data[31:0] !== exp_rd_data[31:0] || exp_rd_data[31:0] !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL bypass_port0: got %h expected %h", rd_data[31:0], exp_rd_data[31:0]);
    end
    vectors++;
    if (rd_data[63:32] !== exp_rd_data[63:32]) begin
      miscompares++;
      $display("[TB] FAIL bypass_port1: got %h expected %h", rd_data[63:32], exp_rd_data[63:32]);
    end
    drive_idle();
    rd_addr = {5'd5, 5'd5};
    tick();
    vectors++;
    if (rd_data !== exp_rd_data) begin
      miscompares++;
      $display("[TB] FAIL stored_read: got %h expected %h", rd_data, exp_rd_data);
    end
  endtask

  task automatic test_zero_reg();
    drive_idle();
    we      = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hDEAD_BEEF;
    sb_set  = 1'b1;
    sb_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    tick();
    vectors++;
    if (rd_data !== exp_rd_data || rd_pending !== exp_rd_pending) begin
      miscompares++;
      $display("[TB] FAIL zero_same_cycle: got %h/%b expected %h/%b",
               rd_data, rd_pending, exp_rd_data, exp_rd_pending);
    end
    drive_idle();
    tick();
    vectors++;
    if (rd_data !== '0 || rd_pending !== '0) begin
      miscompares++;
      $display("[TB] FAIL zero_after: got %h/%b expected 0/0", rd_data, rd_pending);
    end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    sb_set  = 1'b1;
    sb_addr = 5'd7;
    rd_addr = {5'd7, 5'd7};
    tick();
    vectors++;
    if (rd_pending !== exp_rd_pending || exp_rd_pending !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL sb_set: got %b expected %b", rd_pending, exp_rd_pending);
    end
    drive_idle();
    we      = 1'b1;
    wr_addr = 5'd7;
    wr_data = $urandom;
    tick();
    vectors++;
    if (rd_pending !== exp_rd_pending || rd_data !== exp_rd_data) begin
      miscompares++;
      $display("[TB] FAIL sb_clear: got %b/%h expected %b/%h",
               rd_pending, rd_data, exp_rd_pending, exp_rd_data);
    end
    sb_set  = 1'b1;
    sb_addr = 5'd7;
    tick();
    vectors++;
    if (rd_pending !== exp_rd_pending) begin
      miscompares++;
      $display("[TB] FAIL sb_set_wins: got %b expected %b", rd_pending, exp_rd_pending);
    end
    drive_idle();
  endtask

  task automatic test_snoop();
    drive_idle();
    we      = 1'b1;
    wr_addr = 5'd2;
    wr_data = 32'd10;
    tick();
    vectors++;
    if (sys_call_reg !== exp_sys || exp_sys !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL snoop_a: got %h expected %h", sys_call_reg, exp_sys);
    end
    wr_addr = 5'd4;
    wr_data = 32'h1000_0000;
    tick();
    vectors++;
    if (std_out_address !== exp_std || sys_call_reg !== exp_sys) begin
      miscompares++;
      $display("[TB] FAIL snoop_b: got %h/%h expected %h/%h",
               std_out_address, sys_call_reg, exp_std, exp_sys);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a0, a1;
    for (int n = 0; n < 400; n++) begin
      we      = 1'($urandom_range(0, 1));
      wr_addr = (n % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wr_data = $urandom;
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = 5'($urandom_range(0, 7));
      a0      = 5'($urandom_range(0, 7));
      a1      = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      rd_addr = {a1, a0};
      tick();
      vectors++;
      if (rd_data !== exp_rd_data || rd_pending !== exp_rd_pending ||
          sys_call_reg !== exp_sys || std_out_address !== exp_std || init_busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL random %0d: got rd=%h pend=%b sys=%h std=%h busy=%b expected rd=%h pend=%b sys=%h std=%h busy=%b",
                 n, rd_data, rd_pending, sys_call_reg, std_out_address, init_busy,
                 exp_rd_data, exp_rd_pending, exp_sys, exp_std, exp_busy);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_flight();
    // Reset while READY, with outputs likely nonzero.
    rd_addr = {5'd4, 5'd2};
    tick();
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (init_busy !== 1'b1 || rd_data !== '0 || rd_pending !== '0 ||
        sys_call_reg !== '0 || std_out_address !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ready: got busy=%b rd=%h pend=%b sys=%h std=%h expected 1/0/0/0/0",
               init_busy, rd_data, rd_pending, sys_call_reg, std_out_address);
    end
    rst = 1'b0;
    model_reset();
    // Reset again partway into the clear phase (clear_cnt reaches 17).
    we = 1'b1;
    for (int c = 0; c < 17; c++) begin
      wr_addr = 5'($urandom_range(1, 31));
      wr_data = $urandom;
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (init_busy !== 1'b1 || rd_data !== '0 || sys_call_reg !== '0 || std_out_address !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_clear: got busy=%b rd=%h sys=%h std=%h expected 1/0/0/0",
               init_busy, rd_data, sys_call_reg, std_out_address);
    end
    rst = 1'b0;
    model_reset();
    test_clear_sequence();
    // Every entry must have been cleared, including the ones written before reset.
    drive_idle();
    for (int e = 0; e < DEPTH; e += 2) begin
      rd_addr = {5'(e + 1), 5'(e)};
      tick();
      vectors++;
      if (rd_data !== exp_rd_data || rd_pending !== exp_rd_pending) begin
        miscompares++;
        $display("[TB] FAIL post_clear entry %0d: got %h/%b expected %h/%b",
                 e, rd_data, rd_pending, exp_rd_data, exp_rd_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_snoop();
    test_random();
    test_reset_mid_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
